// File: rtl/fiao_issue_scheduler.sv
// fiao_issue_scheduler: in-order allocation, out-of-order issue window.
// Entries are allocated at the tail. Each entry becomes issuable once its
// wake pulse arrives. Issue picks the oldest ready entry, searching from the
// head. The head only retires over freed slots, so holes left behind a still
// valid head keep counting toward occupancy.

// One window slot: valid/ready bits with allocation, wake and issue updates.
module fiao_entry (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic alloc,
  input  logic wake,
  input  logic issue,
  output logic vld,
  output logic rdy
);

  // Allocation wins over a same-cycle wake.
  // A wake only lands on a slot that is already valid.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld <= 1'b0;
      rdy <= 1'b0;
    end else if (alloc) begin
      vld <= 1'b1;
      rdy <= 1'b0;
    end else if (issue) begin
      vld <= 1'b0;
      rdy <= 1'b0;
    end else if (wake && vld) begin
      rdy <= 1'b1;
    end
  end

endmodule

module fiao_issue_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid_i,
  output logic                         enq_ready_o,
  output logic [$clog2(DEPTH)-1:0]     enq_ptr_o,
  input  logic [DEPTH-1:0]             wake_i,
  output logic                         iss_valid_o,
  input  logic                         iss_ready_i,
  output logic [$clog2(DEPTH)-1:0]     iss_ptr_o,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry the wrap flag as their top bit.
  // Because DEPTH is a power of two, a plain increment toggles the flag on wrap.
  logic [PTR_W:0]   head_q, tail_q;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic [DEPTH-1:0] vld, rdy, cand;
  logic [DEPTH-1:0] alloc_vec, issue_vec;
  logic             enq_fire, iss_fire, head_adv;
  logic             sel_found;
  logic [PTR_W-1:0] sel_ptr;

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);
  assign count_o = tail_q - head_q;

  assign enq_ready_o = ~full_o & ~flush_i;
  assign enq_ptr_o   = tail_idx;
  assign enq_fire    = enq_valid_i & enq_ready_o;

  assign cand = vld & rdy;

  // Oldest-first scan: the indices run head, head+1, ..., wrapping to head-1.
  // Iterating in descending age and overwriting leaves the oldest hit.
  always_comb begin : sel_scan
    logic [PTR_W-1:0] idx;
    idx       = '0;
    sel_found = 1'b0;
    sel_ptr   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = head_idx + PTR_W'(k);
      if (cand[idx]) begin
        sel_found = 1'b1;
        sel_ptr   = idx;
      end
    end
  end

  assign iss_valid_o = sel_found & ~flush_i;
  assign iss_ptr_o   = iss_valid_o ? sel_ptr : '0;
  assign iss_fire    = iss_valid_o & iss_ready_i;

  // Head retires one freed slot per cycle and never runs past the tail.
  assign head_adv = ~empty_o & ~vld[head_idx];

  // Per-slot decode of the allocation and issue targets.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign alloc_vec[g] = enq_fire && (tail_idx == PTR_W'(g));
      assign issue_vec[g] = iss_fire && (iss_ptr_o == PTR_W'(g));

      fiao_entry u_ent (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_i),
        .alloc (alloc_vec[g]),
        .wake  (wake_i[g]),
        .issue (issue_vec[g]),
        .vld   (vld[g]),
        .rdy   (rdy[g])
      );
    end
  endgenerate

  // Pointer update: reset and flush both return to an empty window at slot 0.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (enq_fire) tail_q <= tail_q + (PTR_W+1)'(1);
      if (head_adv) head_q <= head_q + (PTR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_fiao_issue_scheduler.sv
// Directed bench for fiao_issue_scheduler at DEPTH=8.
// Inputs change on the falling edge. Outputs are sampled 1ns later, well
// away from the rising edge.
module tb_fiao_issue_scheduler;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             enq_valid_i;
  logic             enq_ready_o;
  logic [PTR_W-1:0] enq_ptr_o;
  logic [DEPTH-1:0] wake_i;
  logic             iss_valid_o;
  logic             iss_ready_i;
  logic [PTR_W-1:0] iss_ptr_o;
  logic             flush_i;
  logic [PTR_W:0]   count_o;
  logic             empty_o;
  logic             full_o;

  int errors = 0;
  int checks = 0;

  fiao_issue_scheduler #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_ptr_o   (enq_ptr_o),
    .wake_i      (wake_i),
    .iss_valid_o (iss_valid_o),
    .iss_ready_i (iss_ready_i),
    .iss_ptr_o   (iss_ptr_o),
    .flush_i     (flush_i),
    .count_o     (count_o),
    .empty_o     (empty_o),
    .full_o      (full_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; the sample point is 1ns later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; enq_valid_i = 1'b0; wake_i = '0; iss_ready_i = 1'b0; flush_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_enq_ready", enq_ready_o, 1);
    chk("rst_enq_ptr",   enq_ptr_o,   0);
    chk("rst_iss_valid", iss_valid_o, 0);
    chk("rst_iss_ptr",   iss_ptr_o,   0);
    chk("rst_count",     count_o,     0);
    chk("rst_empty",     empty_o,     1);
    chk("rst_full",      full_o,      0);

    // Fill all 8 slots back to back, then offer a 9th request.
    enq_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_ptr", enq_ptr_o, i);
      chk("fill_ready", enq_ready_o, 1);
      tick();
    end
    #1;
    chk("full_flag", full_o, 1);
    chk("full_count", count_o, 8);
    chk("full_ready", enq_ready_o, 0);
    tick();
    #1;
    chk("full_count_hold", count_o, 8);
    chk("full_ptr_hold", enq_ptr_o, 0);
    chk("full_empty", empty_o, 0);
    enq_valid_i = 1'b0;

    // Issuing a middle slot leaves the head in place.
    // Draining 0,1,2 then walks the head to slot 4.
    wake_i = 8'b0000_1000;
    #1 chk("wake_latency", iss_valid_o, 0);
    tick();
    wake_i = '0; iss_ready_i = 1'b1;
    #1;
    chk("mid_valid", iss_valid_o, 1);
    chk("mid_ptr", iss_ptr_o, 3);
    tick();
    iss_ready_i = 1'b0;
    #1;
    chk("mid_count", count_o, 8);
    chk("mid_valid_after", iss_valid_o, 0);
    wake_i = 8'b0000_0111;
    tick();
    wake_i = '0; iss_ready_i = 1'b1;
    #1 chk("drain_ptr0", iss_ptr_o, 0); chk("drain_cnt0", count_o, 8);
    tick();
    #1 chk("drain_ptr1", iss_ptr_o, 1); chk("drain_cnt1", count_o, 8);
    tick();
    #1 chk("drain_ptr2", iss_ptr_o, 2); chk("drain_cnt2", count_o, 7);
    tick();
    #1 chk("drain_idle", iss_valid_o, 0); chk("drain_cnt3", count_o, 6);
    tick();
    #1 chk("drain_cnt4", count_o, 5);
    tick();
    #1 chk("drain_cnt5", count_o, 4);
    tick();
    #1 chk("drain_cnt6", count_o, 4);
    iss_ready_i = 1'b0;

    // A stalled consumer keeps seeing slot 4 offered.
    wake_i = 8'b0001_0000;
    tick();
    wake_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", iss_valid_o, 1);
      chk("stall_ptr", iss_ptr_o, 4);
      tick();
    end
    #1 chk("stall_count", count_o, 4);
    enq_valid_i = 1'b1;
    #1 chk("wrap_enq_ptr", enq_ptr_o, 0);
    tick();
    enq_valid_i = 1'b0;
    #1 chk("five_count", count_o, 5);

    // A flush with five slots valid suppresses both handshakes.
    flush_i = 1'b1; enq_valid_i = 1'b1; iss_ready_i = 1'b1;
    #1;
    chk("flush_enq_ready", enq_ready_o, 0);
    chk("flush_iss_valid", iss_valid_o, 0);
    tick();
    flush_i = 1'b0; enq_valid_i = 1'b0; iss_ready_i = 1'b0;
    #1;
    chk("flush_empty", empty_o, 1);
    chk("flush_count", count_o, 0);
    chk("flush_enq_ptr", enq_ptr_o, 0);
    chk("flush_iss_valid_after", iss_valid_o, 0);

    // Refill, then wake slots 2 and 5 together: slot 2 issues first, then 5.
    enq_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("refill_ptr", enq_ptr_o, i);
      tick();
    end
    enq_valid_i = 1'b0;
    wake_i = 8'b0010_0100; iss_ready_i = 1'b1;
    #1 chk("pair_latency", iss_valid_o, 0);
    tick();
    wake_i = '0;
    #1 chk("pair_ptr_a", iss_ptr_o, 2);
    tick();
    #1 chk("pair_ptr_b", iss_ptr_o, 5);
    tick();
    #1 chk("pair_idle", iss_valid_o, 0);

    // Drain 0,1,3,4 so the head walks to 6; tail sits at 0 with its flag set.
    wake_i = 8'b0001_1011;
    tick();
    wake_i = '0;
    for (int i = 0; i < 8; i++) tick();
    iss_ready_i = 1'b0;
    #1 chk("head6_count", count_o, 2);

    // Allocate slots 0 and 1 with a wake arriving in the same cycle.
    // The allocation must win, so neither slot becomes ready.
    enq_valid_i = 1'b1; wake_i = 8'b0000_0001;
    #1 chk("wrap_alloc0", enq_ptr_o, 0);
    tick();
    wake_i = 8'b0000_0010;
    #1 chk("wrap_alloc1", enq_ptr_o, 1);
    tick();
    enq_valid_i = 1'b0; wake_i = '0;
    #1;
    chk("wrap_count", count_o, 4);
    chk("wrap_full", full_o, 0);
    chk("alloc_wins", iss_valid_o, 0);

    // With head at 6, slot 7 is older than slot 0.
    wake_i = 8'b1000_0001; iss_ready_i = 1'b1;
    tick();
    wake_i = '0;
    #1 chk("wrap_ptr_a", iss_ptr_o, 7);
    tick();
    #1 chk("wrap_ptr_b", iss_ptr_o, 0);
    tick();
    #1 chk("wrap_idle", iss_valid_o, 0);
    iss_ready_i = 1'b0;

    // Reset in the middle of operation discards every slot.
    wake_i = 8'b0100_0000;
    tick();
    wake_i = '0; iss_ready_i = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; iss_ready_i = 1'b0;
    #1;
    chk("midrst_empty", empty_o, 1);
    chk("midrst_count", count_o, 0);
    chk("midrst_valid", iss_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
